// File: rtl/escalonador_comandos.sv
// ---------------------------------------------------------------------------
// escalonador_comandos
//
// Command scheduler between two requesters (UART receiver and switch panel)
// and the command executor. Requests are arbitrated round-robin into a small
// circular FIFO. Commands are then issued one at a time with an idle gap of
// HOLD cycles after every handshake. Illegal instruction codes are consumed
// but dropped, and they set a sticky error flag.
//
// Handshake semantics (all interfaces): a transfer happens on the rising edge
// where valid and ready are both 1. A requester keeps valid and its payload
// stable until it sees ready. The scheduler holds cmd_valid and the payload
// stable until cmd_ready, and ignores cmd_ready while cmd_valid is 0.
//
// Ports
//   clock, reset_n                 clock; synchronous active-low reset
//   uart_valid/instrucao/dado      UART request      -> uart_ready (grant)
//   sw_valid/instrucao/dado        switch request    -> sw_ready   (grant)
//   cmd_valid/instrucao/dado       command to executor <- cmd_ready
//   nivel                          FIFO occupancy, including the offered head
//   ocupado                        FIFO not empty or output FSM not idle
//   erro                           sticky: an illegal code was dropped
//   estado                         output FSM state (observation only)
// ---------------------------------------------------------------------------
module escalonador_comandos #(
   parameter int DEPTH = 4,
   parameter int HOLD  = 2
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       uart_valid,
   input  logic [3:0]                 uart_instrucao,
   input  logic [3:0]                 uart_dado,
   output logic                       uart_ready,
   input  logic                       sw_valid,
   input  logic [3:0]                 sw_instrucao,
   input  logic [3:0]                 sw_dado,
   output logic                       sw_ready,
   output logic                       cmd_valid,
   output logic [3:0]                 cmd_instrucao,
   output logic [3:0]                 cmd_dado,
   input  logic                       cmd_ready,
   output logic [$clog2(DEPTH):0]     nivel,
   output logic                       ocupado,
   output logic                       erro,
   output logic [1:0]                 estado
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EMITINDO = 2'd1,
      ESPERA   = 2'd2
   } estado_t;

   estado_t         estado_q, estado_d;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [NW-1:0]   count, count_d;
   logic [7:0]      mem [DEPTH];
   logic [3:0]      hold_cnt;
   logic            prio_sw;        // 0: UART wins a tie, 1: switch wins
   logic            full;
   logic            gnt_u, gnt_s, granted;
   logic [3:0]      sel_instrucao, sel_dado;
   logic            legal, push, illegal;
   logic            load_head, pop;

   // Full is the registered occupancy: a pop on this edge does not free a
   // slot for a push on the same edge.
   assign full = (count == NW'(DEPTH));

   always_comb begin
      gnt_u = 1'b0;
      gnt_s = 1'b0;
      if (reset_n && !full) begin
         if (uart_valid && sw_valid) begin
            if (prio_sw) gnt_s = 1'b1;
            else         gnt_u = 1'b1;
         end else if (uart_valid) begin
            gnt_u = 1'b1;
         end else if (sw_valid) begin
            gnt_s = 1'b1;
         end
      end
   end

   assign granted       = gnt_u | gnt_s;
   assign uart_ready    = gnt_u;
   assign sw_ready      = gnt_s;
   assign sel_instrucao = gnt_s ? sw_instrucao : uart_instrucao;
   assign sel_dado      = gnt_s ? sw_dado      : uart_dado;

   // Legal codes: 1 limpar, 2 carregar, 4 mostrar.
   assign legal   = (sel_instrucao == 4'd1) || (sel_instrucao == 4'd2) ||
                    (sel_instrucao == 4'd4);
   assign push    = granted && legal;
   assign illegal = granted && !legal;

   // Output FSM: next state and control strobes.
   always_comb begin
      estado_d  = estado_q;
      load_head = 1'b0;
      pop       = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (count != '0) begin
               load_head = 1'b1;
               estado_d  = EMITINDO;
            end
         end
         EMITINDO: begin
            if (cmd_ready) begin
               pop      = 1'b1;
               estado_d = (HOLD > 0) ? ESPERA : OCIOSO;
            end
         end
         ESPERA: begin
            // Leave when the counter steps down to zero on this edge.
            if (hold_cnt <= 4'd1) estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   assign count_d = count + NW'(push) - NW'(pop);

   // Storage has no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {sel_instrucao, sel_dado};
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado_q      <= OCIOSO;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         prio_sw       <= 1'b0;
         hold_cnt      <= 4'd0;
         cmd_valid     <= 1'b0;
         cmd_instrucao <= 4'd0;
         cmd_dado      <= 4'd0;
         erro          <= 1'b0;
         ocupado       <= 1'b0;
      end else begin
         estado_q <= estado_d;
         count    <= count_d;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         // Pointer passes to the other requester after any grant.
         if (granted) prio_sw <= gnt_u;
         if (illegal) erro <= 1'b1;
         if (load_head) begin
            cmd_valid                 <= 1'b1;
            {cmd_instrucao, cmd_dado} <= mem[rd_ptr];
         end else if (pop) begin
            cmd_valid <= 1'b0;
         end
         if (pop)                    hold_cnt <= 4'(HOLD);
         else if (estado_q == ESPERA) hold_cnt <= hold_cnt - 4'd1;
         ocupado <= (count_d != '0) || (estado_d != OCIOSO);
      end
   end

   assign nivel  = count;
   assign estado = estado_q;

endmodule

// File: tb/tb_escalonador_comandos.sv
module tb_escalonador_comandos;

   localparam int DEPTH = 4;
   localparam int HOLD  = 2;
   localparam int NW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset_n;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic          uart_valid, sw_valid, cmd_ready;
   logic [3:0]    uart_instrucao, uart_dado, sw_instrucao, sw_dado;
   logic          uart_ready, sw_ready, cmd_valid, ocupado, erro;
   logic [3:0]    cmd_instrucao, cmd_dado;
   logic [NW-1:0] nivel;
   logic [1:0]    estado;

   escalonador_comandos #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .uart_valid     (uart_valid),
      .uart_instrucao (uart_instrucao),
      .uart_dado      (uart_dado),
      .uart_ready     (uart_ready),
      .sw_valid       (sw_valid),
      .sw_instrucao   (sw_instrucao),
      .sw_dado        (sw_dado),
      .sw_ready       (sw_ready),
      .cmd_valid      (cmd_valid),
      .cmd_instrucao  (cmd_instrucao),
      .cmd_dado       (cmd_dado),
      .cmd_ready      (cmd_ready),
      .nivel          (nivel),
      .ocupado        (ocupado),
      .erro           (erro),
      .estado         (estado)
   );

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit legal_code(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2) || (c == 4'd4);
   endfunction

   // ---------------- reference model ----------------
   // Abstract view: a count of stored commands, a tie-break owner, a sticky
   // error, whether a command is on offer, and the number of edges since the
   // last executor handshake (new offers need at least HOLD+1 of them).
   int m_count  = 0;
   bit m_ptr_sw = 1'b0;
   bit m_valid  = 1'b0;
   bit m_erro   = 1'b0;
   int m_age    = HOLD + 1;

   always @(negedge clock) begin : predictor
      bit eu, es, push, hs, nv;
      logic [7:0] c;
      eu = 1'b0; es = 1'b0; push = 1'b0;
      if (reset_n === 1'b1 && m_count < DEPTH) begin
         if (uart_valid && sw_valid) begin
            if (m_ptr_sw) es = 1'b1; else eu = 1'b1;
         end else if (uart_valid) eu = 1'b1;
         else if (sw_valid)       es = 1'b1;
      end
      check("uart_ready", uart_ready, eu);
      check("sw_ready", sw_ready, es);
      check("nivel", nivel, m_count);
      check("cmd_valid", cmd_valid, m_valid);
      check("erro", erro, m_erro);
      check("ocupado", ocupado, (m_count != 0) || m_valid || (m_age - 1 < HOLD));
      if (reset_n !== 1'b1) begin
         m_count = 0; m_ptr_sw = 1'b0; m_valid = 1'b0; m_erro = 1'b0;
         m_age = HOLD + 1;
         exp_q.delete();
      end else begin
         hs = m_valid && cmd_ready;
         if (eu || es) begin
            c = es ? {sw_instrucao, sw_dado} : {uart_instrucao, uart_dado};
            if (legal_code(c[7:4])) begin
               exp_q.push_back(c);
               push = 1'b1;
            end else begin
               m_erro = 1'b1;
            end
            m_ptr_sw = eu;
         end
         nv = m_valid ? !hs : (m_age >= HOLD + 1 && m_count > 0);
         m_count = m_count + int'(push) - int'(hs);
         m_valid = nv;
         m_age   = hs ? 1 : (m_age < 1000 ? m_age + 1 : m_age);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clock) begin : monitor
      logic [7:0] e;
      if (reset_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_cmd", {cmd_instrucao, cmd_dado}, 32'hFFFF);
         end else begin
            e = exp_q.pop_front();
            check("cmd_payload", {cmd_instrucao, cmd_dado}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_u(input logic [3:0] i, input logic [3:0] d);
      bit got;
      int n;
      got = 1'b0; n = 0;
      uart_valid = 1'b1; uart_instrucao = i; uart_dado = d;
      while (!got && n < 300) begin
         @(negedge clock);
         got = uart_ready;
         tick();
         n++;
      end
      uart_valid = 1'b0;
      if (!got) check("uart_accept_timeout", 0, 1);
   endtask

   task automatic send_s(input logic [3:0] i, input logic [3:0] d);
      bit got;
      int n;
      got = 1'b0; n = 0;
      sw_valid = 1'b1; sw_instrucao = i; sw_dado = d;
      while (!got && n < 300) begin
         @(negedge clock);
         got = sw_ready;
         tick();
         n++;
      end
      sw_valid = 1'b0;
      if (!got) check("sw_accept_timeout", 0, 1);
   endtask

   function automatic logic [3:0] rand_code();
      logic [3:0] tab [3];
      tab[0] = 4'd1; tab[1] = 4'd2; tab[2] = 4'd4;
      if ($urandom_range(0, 99) < 85) return tab[$urandom_range(0, 2)];
      return 4'($urandom_range(0, 15));
   endfunction

   bit rand_done;

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0; cmd_ready = 1'b0;
      uart_valid = 1'b1; uart_instrucao = 4'd2; uart_dado = 4'd6;
      sw_valid   = 1'b1; sw_instrucao   = 4'd1; sw_dado   = 4'd7;
      repeat (3) tick();
      // Release with both requesting: UART must win first.
      reset_n = 1'b1;
      tick();
      uart_valid = 1'b0; sw_valid = 1'b0;
      cmd_ready = 1'b1;
      repeat (10) tick();

      // Single command
      send_u(4'd2, 4'hA);
      repeat (8) tick();

      // Fairness with both requesters busy
      fork
         repeat (6) send_u(4'd4, 4'd3);
         repeat (6) send_s(4'd1, 4'd5);
      join
      repeat (30) tick();

      // Full FIFO, then drain; fifth push lands after the first pop
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_u(4'd2, 4'(i));
      fork
         send_u(4'd2, 4'd4);
         begin
            repeat (6) tick();
            cmd_ready = 1'b1;
         end
      join
      repeat (30) tick();

      // Illegal code, then legal traffic with erro held
      send_s(4'd7, 4'd9);
      send_u(4'd1, 4'd1);
      send_s(4'd4, 4'd2);
      repeat (15) tick();

      // Reset while a command is on offer
      cmd_ready = 1'b0;
      send_u(4'd4, 4'd1);
      send_u(4'd4, 4'd2);
      send_u(4'd4, 4'd3);
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      cmd_ready = 1'b1;
      repeat (10) tick();

      // Randomized traffic with random executor back-pressure
      rand_done = 1'b0;
      fork
         begin
            fork
               for (int k = 0; k < 40; k++) begin
                  send_u(rand_code(), 4'($urandom_range(0, 15)));
                  repeat ($urandom_range(0, 3)) tick();
               end
               for (int k = 0; k < 40; k++) begin
                  send_s(rand_code(), 4'($urandom_range(0, 15)));
                  repeat ($urandom_range(0, 3)) tick();
               end
            join
            rand_done = 1'b1;
         end
         while (!rand_done) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      join

      cmd_ready = 1'b1;
      repeat (60) tick();
      check("drained", exp_q.size(), 0);

      // Final reset clears erro and occupancy
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/escalonador_comandos.md
# escalonador_comandos

Command scheduler in front of the command executor. It accepts 4-bit instruction / 4-bit data pairs from two requesters, the UART receiver and the switch panel. It arbitrates them round-robin into a small FIFO and issues them one at a time to the executor over a valid/ready handshake, with an enforced idle gap between commands. Illegal instruction codes are filtered before they reach the executor.

## Interface
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- HOLD, 2: idle cycles inserted after each issued command, 0..15.

- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- uart_valid  in  1  UART requester has a command
- uart_instrucao  in  4  UART instruction code
- uart_dado  in  4  UART data
- uart_ready  out  1  UART command accepted this cycle
- sw_valid  in  1  switch-panel requester has a command
- sw_instrucao  in  4  switch instruction code
- sw_dado  in  4  switch data
- sw_ready  out  1  switch command accepted this cycle
- cmd_valid  out  1  command offered to executor
- cmd_instrucao  out  4  offered instruction
- cmd_dado  out  4  offered data
- cmd_ready  in  1  executor takes command
- nivel  out  log2(DEPTH)+1  FIFO occupancy, including the offered head
- ocupado  out  1  nivel≠0 or FSM not OCIOSO
- erro  out  1  sticky: an illegal code was dropped

## Operation
- Legal codes: 1 limpar, 2 carregar, 4 mostrar. Any other code is consumed (ready=1) but not enqueued, and sets erro. erro stays set until reset.
- Arbitration is combinational from the valids, the registered full flag, and the priority pointer.
  - Grant only when the FIFO is not full. Full is the pre-edge value; there is no pop-bypass.
  - Only one requester is granted per cycle. ready equals grant.
  - With exactly one valid, that requester is granted.
  - With both valid, the requester at the pointer is granted.
  - The pointer moves to the other requester after every grant, legal or illegal. Reset value: UART.
- FIFO: circular, write pointer/read pointer/count. A push on an accepted legal command. A pop on an executor handshake (cmd_valid & cmd_ready). Push and pop in the same cycle leave nivel unchanged.
- Output FSM:
  - OCIOSO: if nivel≠0, latch the head into cmd_instrucao/cmd_dado, set cmd_valid, go to EMITINDO.
  - EMITINDO: cmd_valid, cmd_instrucao and cmd_dado are held stable until cmd_ready. On the handshake: pop, clear cmd_valid, load the counter with HOLD. Go to ESPERA if HOLD>0, else OCIOSO.
  - ESPERA: decrement the counter each cycle. When it reaches 0, go to OCIOSO.
- Data order out equals acceptance order. No command is reordered, duplicated or lost.

## Timing
- Reset (reset_n low at an edge):
  - cmd_valid, cmd_instrucao, cmd_dado, erro, ocupado = 0.
  - nivel = 0, FIFO emptied, pointer = UART, FSM = OCIOSO.
  - uart_ready and sw_ready are forced to 0 while reset_n is low.
- Reset mid-operation: pending and offered commands are discarded and cmd_valid is 0 after the edge, regardless of cmd_ready.
- Latency: a command accepted at edge k into an empty FIFO with the FSM in OCIOSO appears with cmd_valid=1 after edge k+1.
- Back-to-back: after a handshake at edge k, cmd_valid is low for exactly HOLD+1 cycles, then the next queued command is presented.
- A full FIFO with a handshake pop at the same edge still refuses the push in that cycle. ready returns one cycle later.
- nivel and ocupado are registered. They update on the edge of the push/pop.
- cmd_ready is ignored while cmd_valid=0.

## Test plan
- Reset: reset_n low 3 cycles with uart_valid=sw_valid=1 and legal codes → both readies 0, cmd_valid 0, nivel 0, erro 0. Release → UART granted first.
- Single command: UART (2, 0xA) for 1 cycle, cmd_ready=1 → uart_ready=1, cmd_valid high one edge later with instrucao 2, dado A, held one cycle. nivel goes 1→0.
- Fairness: both valid continuously with UART (4,3) and switch (1,5), cmd_ready=1 → grants alternate U,S,U,S… Executor sees 4/3, 1/5, 4/3… with 3 low cycles between commands (HOLD=2).
- Full: cmd_ready=0, five legal UART commands (2,0)…(2,4) → first four accepted, nivel=4, uart_ready=0 on the fifth. Raise cmd_ready → data 0,1,2,3 issued in order, and the fifth is accepted the cycle after the first pop.
- Illegal code: switch (7,9) → sw_ready=1, nivel unchanged, no cmd_valid, erro=1. erro persists through later legal traffic until reset_n=0.
- Reset mid-offer: cmd_valid=1, cmd_ready=0, nivel=3, then reset_n=0 for one edge → cmd_valid 0 and nivel 0 after that edge. No stale command is issued after release.
